// File: rtl/fft_frame_ctrl.sv
// Frame-level controller in front of a streaming FFT core: accepts frame requests,
// paces samples into the core, and tracks the ldn of every frame still in flight.
module fft_frame_ctrl #(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_OUT    = 2
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        start_i,
  input  logic [3:0]  ldn_i,
  output logic        start_ack_o,
  output logic        err_ldn_o,
  input  logic        src_val_i,
  output logic        src_rdy_o,
  output logic        core_block_sync_o,
  output logic        core_data_val_o,
  output logic [3:0]  core_ldn_o,
  input  logic        core_out_sync_i,
  output logic [3:0]  mon_ldn_o,
  output logic        busy_o,
  output logic [1:0]  outstanding_o,
  output logic [15:0] frame_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_LOAD, S_GAP} state_e;

  localparam logic [1:0] MAX_OUT_L = 2'(MAX_OUT);
  localparam logic [3:0] GAP_LAST  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic [3:0]  core_ldn_q, core_ldn_d;
  logic [3:0]  mon_ldn_q, mon_ldn_d;
  logic [1:0]  outst_q, outst_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]  fifo_q [3];
  logic [3:0]  fifo_d [3];

  logic        ldn_ok, push, pop;
  logic [1:0]  wr_idx;
  logic [11:0] frame_len;
  logic [10:0] last_idx;

  assign ldn_ok    = (ldn_i >= 4'd3) && (ldn_i <= 4'd11);
  assign frame_len = 12'd1 << core_ldn_q;
  assign last_idx  = 11'(frame_len - 12'd1);
  assign pop       = core_out_sync_i && (outst_q != 2'd0);

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    gap_d             = gap_q;
    core_ldn_d        = core_ldn_q;
    frame_cnt_d       = frame_cnt_q;
    start_ack_o       = 1'b0;
    err_ldn_o         = 1'b0;
    src_rdy_o         = 1'b0;
    core_block_sync_o = 1'b0;
    core_data_val_o   = 1'b0;
    push              = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (!ldn_ok) begin
            err_ldn_o = 1'b1;
          end else if (outst_q < MAX_OUT_L) begin
            start_ack_o = 1'b1;
            push        = 1'b1;
            core_ldn_d  = ldn_i;
            state_d     = S_SYNC;
          end
        end
      end
      S_SYNC: begin
        core_block_sync_o = 1'b1;
        cnt_d             = '0;
        state_d           = S_LOAD;
      end
      S_LOAD: begin
        src_rdy_o       = 1'b1;
        core_data_val_o = src_val_i;
        if (src_val_i) begin
          cnt_d = cnt_q + 11'd1;
          if (cnt_q == last_idx) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            gap_d       = GAP_LAST;
            state_d     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // In-flight ldn FIFO: head at index 0, a pop shifts down, and a push lands
  // just past the entries that survive this cycle's pop.
  always_comb begin
    fifo_d    = fifo_q;
    mon_ldn_d = mon_ldn_q;
    wr_idx    = outst_q - {1'b0, pop};
    if (pop) begin
      mon_ldn_d = fifo_q[0];
      fifo_d[0] = fifo_q[1];
      fifo_d[1] = fifo_q[2];
    end
    if (push) fifo_d[wr_idx] = ldn_i;

    unique case ({push, pop})
      2'b10:   outst_d = outst_q + 2'd1;
      2'b01:   outst_d = outst_q - 2'd1;
      default: outst_d = outst_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      core_ldn_q  <= 4'd3;
      mon_ldn_q   <= 4'd3;
      outst_q     <= '0;
      frame_cnt_q <= '0;
      // NOTE: the FIFO storage is only three nibbles, so it is reset outright
      // rather than relying on the occupancy count alone.
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      core_ldn_q  <= core_ldn_d;
      mon_ldn_q   <= mon_ldn_d;
      outst_q     <= outst_d;
      frame_cnt_q <= frame_cnt_d;
      fifo_q      <= fifo_d;
    end
  end

  assign core_ldn_o    = core_ldn_q;
  assign mon_ldn_o     = mon_ldn_q;
  assign busy_o        = (state_q != S_IDLE);
  assign outstanding_o = outst_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles inserted after each frame's last sample (range 0..15).
REQ-002 SHALL have parameter MAX_OUT, default 2, meaning the maximum number of frames in flight in the FFT core (range 1..3).
REQ-003 SHALL have port clk_sys, input, 1 bit: system clock, rising-edge active.
REQ-004 SHALL have port rst_sys_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start_i, input, 1 bit: frame request, level-held by the requester until start_ack_o.
REQ-006 SHALL have port ldn_i, input, 4 bits: log2 of the frame length, sampled with start_i.
REQ-007 SHALL have port start_ack_o, output, 1 bit: one-cycle pulse when a request is accepted.
REQ-008 SHALL have port err_ldn_o, output, 1 bit: one-cycle pulse when a request is rejected for an illegal ldn.
REQ-009 SHALL have port src_val_i, input, 1 bit: source sample valid.
REQ-010 SHALL have port src_rdy_o, output, 1 bit: controller ready to accept a sample.
REQ-011 SHALL have port core_block_sync_o, output, 1 bit: frame-start strobe to the FFT core.
REQ-012 SHALL have port core_data_val_o, output, 1 bit: sample-valid strobe to the FFT core.
REQ-013 SHALL have port core_ldn_o, output, 4 bits: ldn of the frame currently being loaded.
REQ-014 SHALL have port core_out_sync_i, input, 1 bit: block_sync from the core output side.
REQ-015 SHALL have port mon_ldn_o, output, 4 bits: ldn of the frame currently emerging from the core, for the monitor.
REQ-016 SHALL have port busy_o, output, 1 bit: FSM not in IDLE.
REQ-017 SHALL have port outstanding_o, output, 2 bits: number of frames in flight.
REQ-018 SHALL have port frame_cnt_o, output, 16 bits: count of fully loaded frames.

Function
REQ-019 SHALL implement FSM states IDLE, SYNC, LOAD, GAP; busy_o = (state != IDLE).
REQ-020 IDLE: when start_i=1 and ldn_i is outside 3..11, SHALL pulse err_ldn_o, give no ack, and stay in IDLE.
REQ-021 IDLE: when start_i=1, ldn_i is in 3..11 and outstanding_o < MAX_OUT, SHALL pulse start_ack_o, register ldn_i into core_ldn_o, push ldn_i into the ldn FIFO (depth MAX_OUT), increment outstanding, and go to SYNC.
REQ-022 IDLE: when outstanding_o = MAX_OUT, SHALL ignore start_i with no ack and no error; the requester holds.
REQ-023 start_i outside IDLE SHALL be ignored.
REQ-024 SYNC: SHALL assert core_block_sync_o for exactly one cycle, clear the sample counter (11 bits), and go to LOAD.
REQ-025 LOAD: src_rdy_o=1; core_data_val_o = src_val_i AND (state=LOAD), combinational, zero latency; the counter increments on each accepted sample.
REQ-026 LOAD: on the accepted sample with counter = 2^ldn - 1, SHALL increment frame_cnt_o (wrapping 0xFFFF->0) and go to GAP, or to IDLE if GAP_CYCLES=0.
REQ-027 GAP: src_rdy_o=0 for GAP_CYCLES cycles, then IDLE; gap cycles SHALL NOT be consumed by absent src_val_i in LOAD.
REQ-028 Outside LOAD, src_rdy_o=0 and core_data_val_o=0 regardless of src_val_i.
REQ-029 core_out_sync_i with outstanding>0 SHALL pop the FIFO head into mon_ldn_o (registered, 1-cycle latency) and decrement outstanding.
REQ-030 core_out_sync_i with outstanding=0 SHALL be ignored; mon_ldn_o holds.
REQ-031 Simultaneous accept and pop SHALL leave outstanding unchanged, with the FIFO pushing and popping correctly in the same cycle.

Reset
REQ-032 rst_sys_n low SHALL force, asynchronously, state=IDLE, all strobes=0, src_rdy_o=0, core_ldn_o=3, mon_ldn_o=3, outstanding_o=0, frame_cnt_o=0, the sample counter=0, and an empty FIFO.
REQ-033 Reset mid-LOAD SHALL abandon the partial frame, with no frame_cnt_o increment; the first cycle after release is IDLE.

Verification
REQ-034 ldn_i=3, start held, src_val_i always 1 -> ack pulse; block_sync 1 cycle later; 8 data_val cycles; frame_cnt=1; 2 gap cycles; then IDLE.
REQ-035 ldn_i=12 with start -> err_ldn_o pulse; no ack; state stays IDLE; outstanding=0.
REQ-036 Three back-to-back ldn=4 requests with no core_out_sync_i -> two frames loaded; third request unacked with busy_o=0 and outstanding=2; one core_out_sync_i -> third acked next cycle, mon_ldn_o=4.
REQ-037 ldn=5 with src_val_i toggling 1/0 -> exactly 32 data_val pulses over 63 LOAD cycles; GAP entered only after the 32nd pulse.
REQ-038 core_out_sync_i coincident with an ack at outstanding=1 -> outstanding stays 1; mon_ldn_o = older ldn.
REQ-039 rst_sys_n low at sample 100 of an ldn=11 frame -> all outputs at reset values immediately; frame_cnt=0.
